// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Fetch response pipeline: carries accept/err/zero flags alongside the RAM
// read register and holds the last response while no new one arrives.
module imem_rd_pipe
  import imem_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_err,
  input  logic          in_zero,
  input  logic [DW-1:0] ram_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  localparam int STAGES = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                          (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

  logic v1_q, v1_d;
  logic e1_q, e1_d;
  logic z1_q, z1_d;

  always_comb begin
    v1_d = in_valid;
    e1_d = e1_q;
    z1_d = z1_q;
    if (in_valid) begin
      e1_d = in_err;
      z1_d = in_zero;
    end
  end

  // z1 resets high so the unreset RAM register reads as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      z1_q <= 1'b1;
    end else begin
      v1_q <= v1_d;
      e1_q <= e1_d;
      z1_q <= z1_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_lat1
      assign out_valid = v1_q;
      assign out_err   = e1_q;
      assign out_data  = z1_q ? '0 : ram_data;
    end else begin : g_lat2
      logic          v2_q, v2_d;
      logic          e2_q, e2_d;
      logic [DW-1:0] d2_q, d2_d;

      always_comb begin
        v2_d = v1_q;
        e2_d = e2_q;
        d2_d = d2_q;
        if (v1_q) begin
          e2_d = e1_q;
          d2_d = z1_q ? '0 : ram_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          v2_q <= 1'b0;
          e2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v2_d;
          e2_q <= e2_d;
          d2_q <= d2_d;
        end
      end

      assign out_valid = v2_q;
      assign out_err   = e2_q;
      assign out_data  = d2_q;
    end
  endgenerate

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with byte-addressed fetch port,
// byte-enabled load port and a sequential clear engine.
module imem_sync
  import imem_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 12,
  parameter int DEPTH          = 1024,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_err,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            clr_done
);

  localparam int NB = DW / 8;
  localparam int OB = clog2(NB);
  localparam int IW = AW - OB;
  localparam int MW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [IW:0]   DEPTH_L = (IW + 1)'(DEPTH);
  localparam logic [CW-1:0] LAST_L  = CW'(DEPTH - 1);

  logic [IW-1:0] rd_idx, wr_idx;
  logic [MW-1:0] rd_widx;
  logic          rd_oor, rd_mis, wr_oor, rd_accept;

  assign rd_idx    = rd_addr[AW-1:OB];
  assign wr_idx    = wr_addr[AW-1:OB];
  assign rd_oor    = {1'b0, rd_idx} >= DEPTH_L;
  assign wr_oor    = {1'b0, wr_idx} >= DEPTH_L;
  assign rd_accept = rd_req && rd_ready;
  // Out-of-range fetches still read the array, so steer them to a legal word.
  assign rd_widx   = rd_oor ? '0 : rd_idx[MW-1:0];

  generate
    if (OB > 0) begin : g_align
      logic wr_lsb_unused;
      assign rd_mis        = |rd_addr[OB-1:0];
      assign wr_lsb_unused = |wr_addr[OB-1:0];
    end else begin : g_noalign
      assign rd_mis = 1'b0;
    end
  endgenerate

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          first_q, first_d;
  logic          auto_start;

  assign auto_start = (CLEAR_ON_RESET != 0) && first_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start || auto_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_L) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      first_q <= first_d;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign rd_ready = (state_q == ST_IDLE);
  assign clr_done = done_q;

  // Single write port shared by the loader and the clear engine.
  logic          mem_we;
  logic [MW-1:0] mem_widx;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_be;

  always_comb begin
    mem_we    = wr_en && !wr_oor;
    mem_widx  = wr_idx[MW-1:0];
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q[MW-1:0];
      mem_wdata = '0;
      mem_be    = '1;
    end
  end

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_rd_q;

  // Read and write in one process give read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (rd_accept) ram_rd_q <= mem[rd_widx];
  end

  imem_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_accept),
    .in_err    (rd_oor || rd_mis),
    .in_zero   (rd_oor),
    .ram_data  (ram_rd_q),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .out_err   (rd_err)
  );

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench: two instances (read latency 1 and 2) share stimulus and
// are checked each cycle against a behavioural memory model.
module tb_imem_sync;

  localparam int DEPTH = 20;

  logic        clk = 1'b0;
  logic        reset, rd_req, wr_en, clr_start;
  logic [7:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic        a_rd_ready, a_rd_valid, a_rd_err, a_clr_busy, a_clr_done;
  logic [31:0] a_rd_data;
  logic        b_rd_ready, b_rd_valid, b_rd_err, b_clr_busy, b_clr_done;
  logic [31:0] b_rd_data;
  logic        c_rd_ready, c_rd_valid, c_rd_err, c_clr_busy, c_clr_done;
  logic [31:0] c_rd_data;

  always #5 clk = ~clk;

  imem_sync #(.DW(32), .AW(8), .DEPTH(DEPTH), .RD_LAT(1), .CLEAR_ON_RESET(0)) dut_a (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(a_rd_ready),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clr_start(clr_start),
    .clr_busy(a_clr_busy), .clr_done(a_clr_done));

  imem_sync #(.DW(32), .AW(8), .DEPTH(DEPTH), .RD_LAT(2), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(b_rd_ready),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clr_start(clr_start),
    .clr_busy(b_clr_busy), .clr_done(b_clr_done));

  imem_sync #(.DW(32), .AW(8), .DEPTH(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut_c (
    .clk(clk), .reset(reset), .rd_req(1'b0), .rd_addr(8'h00), .rd_ready(c_rd_ready),
    .rd_valid(c_rd_valid), .rd_data(c_rd_data), .rd_err(c_rd_err), .wr_en(1'b0),
    .wr_addr(8'h00), .wr_data(32'h0), .wr_be(4'h0), .clr_start(1'b0),
    .clr_busy(c_clr_busy), .clr_done(c_clr_done));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: word array, clear countdown and per-edge fetch history.
  logic [31:0] mem_m [DEPTH];
  bit          busy_m = 0, done_m = 0, model_ok = 0;
  int          left_m = 0;
  int          cyc = 0;
  bit          acc_h [8192];
  logic [31:0] d_h [8192];
  bit          e_h [8192];
  bit          ev [1:2];
  logic [31:0] ed [1:2];
  bit          ee [1:2];

  initial begin
    forever begin
      int ri, wi, k;
      bit acc, err, nd;
      logic [31:0] rdat;
      @(posedge clk);
      ri   = int'(rd_addr) / 4;
      wi   = int'(wr_addr) / 4;
      acc  = rd_req && !busy_m;
      err  = (ri >= DEPTH) || (rd_addr[1:0] != 2'b00);
      rdat = (ri < DEPTH) ? mem_m[ri] : 32'h0;
      nd   = 0;
      if (busy_m) begin
        mem_m[DEPTH - left_m] = 32'h0;
        left_m--;
        if (left_m == 0) begin
          busy_m = 0;
          nd = 1;
        end
      end else begin
        if (wr_en && wi < DEPTH)
          for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem_m[wi][b*8 +: 8] = wr_data[b*8 +: 8];
        if (clr_start) begin
          busy_m = 1;
          left_m = DEPTH;
        end
      end
      done_m = nd;
      if (reset) begin
        busy_m = 0;
        done_m = 0;
        acc = 0;
        model_ok = 1;
        for (int l = 1; l <= 2; l++) begin
          ev[l] = 0; ed[l] = 32'h0; ee[l] = 0;
        end
      end
      acc_h[cyc] = acc;
      d_h[cyc]   = err && ri >= DEPTH ? 32'h0 : rdat;
      e_h[cyc]   = err;
      if (!reset) begin
        for (int l = 1; l <= 2; l++) begin
          k = cyc - l + 1;
          ev[l] = (k >= 0) && acc_h[k];
          if (ev[l]) begin
            ed[l] = d_h[k];
            ee[l] = e_h[k];
          end
        end
      end
      if (cyc < 8191) cyc++;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("a_valid", a_rd_valid, ev[1]);
        check("a_data", a_rd_data, ed[1]);
        check("a_err", a_rd_err, ee[1]);
        check("b_valid", b_rd_valid, ev[2]);
        check("b_data", b_rd_data, ed[2]);
        check("b_err", b_rd_err, ee[2]);
        check("a_ready", a_rd_ready, !busy_m);
        check("a_busy", a_clr_busy, busy_m);
        check("a_done", a_clr_done, done_m);
        check("b_ready", b_rd_ready, !busy_m);
        check("b_busy", b_clr_busy, busy_m);
        check("b_done", b_clr_done, done_m);
        if (b_rd_valid) $display("rsp cyc=%0d data=%h err=%0b", cyc, b_rd_data, b_rd_err);
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic fetch_chk(input string name, input logic [7:0] a,
                           input logic [31:0] exp_d, input logic exp_e);
    rd_req = 1; rd_addr = a;
    @(negedge clk);
    rd_req = 0;
    check({name, "_valid"}, a_rd_valid, 1);
    check({name, "_data"}, a_rd_data, exp_d);
    check({name, "_err"}, a_rd_err, exp_e);
  endtask

  initial begin
    int nb, nd, r;
    bit [5:0] cb, cd, cr;
    bit [4:0] bv;
    logic [31:0] bd [1:3];

    reset = 1; rd_req = 0; wr_en = 0; clr_start = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", a_rd_valid, 0);
    check("rst_data", a_rd_data, 0);
    check("rst_err", a_rd_err, 0);
    check("rst_ready", a_rd_ready, 1);
    check("rst_busy", a_clr_busy, 0);
    check("rst_done", a_clr_done, 0);

    // Initial clear; dut_c clears by itself after reset.
    reset = 0; clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    nb = 0; nd = 0; cb = 0; cd = 0; cr = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_clr_busy) nb++;
      if (a_clr_done) nd++;
      if (i < 6) begin
        cb[i] = c_clr_busy; cd[i] = c_clr_done; cr[i] = c_rd_ready;
      end
      wr_en = (i < 18); wr_addr = 8'(i * 4); wr_data = 32'hBAD00000 | 32'(i); wr_be = 4'hF;
      clr_start = (i == 5);
      @(negedge clk);
    end
    wr_en = 0; clr_start = 0;
    check("clr_busy_cycles", nb, DEPTH);
    check("clr_done_pulses", nd, 1);
    check("cor_busy", 32'(cb), 32'h0F);
    check("cor_done", 32'(cd), 32'h10);
    check("cor_ready", 32'(cr), 32'h30);
    fetch_chk("clr_ignored_wr", 8'h0C, 32'h0, 0);

    wr(8'h00, 32'h20080005, 4'hF);
    fetch_chk("load0", 8'h00, 32'h20080005, 0);
    wr(8'h10, 32'hFFFFFFFF, 4'hF);
    wr(8'h10, 32'h000000AB, 4'b0001);
    fetch_chk("byte_en", 8'h10, 32'hFFFFFFAB, 0);
    @(negedge clk);
    check("hold_valid", a_rd_valid, 0);
    check("hold_data", a_rd_data, 32'hFFFFFFAB);

    wr(8'h04, 32'h11111111, 4'hF);
    wr(8'h08, 32'h22222222, 4'hF);
    rd_req = 1; rd_addr = 8'h00;
    @(negedge clk); bv[0] = b_rd_valid; rd_addr = 8'h04;
    @(negedge clk); bv[1] = b_rd_valid; bd[1] = b_rd_data; rd_addr = 8'h08;
    @(negedge clk); bv[2] = b_rd_valid; bd[2] = b_rd_data; rd_req = 0;
    @(negedge clk); bv[3] = b_rd_valid; bd[3] = b_rd_data;
    @(negedge clk); bv[4] = b_rd_valid;
    check("b2b_valid", 32'(bv), 32'h0E);
    check("b2b_d0", bd[1], 32'h20080005);
    check("b2b_d1", bd[2], 32'h11111111);
    check("b2b_d2", bd[3], 32'h22222222);

    fetch_chk("misaligned", 8'h02, 32'h20080005, 1);
    wr(8'h4C, 32'h13131313, 4'hF);
    fetch_chk("last_word", 8'h4C, 32'h13131313, 0);
    wr(8'h50, 32'h77777777, 4'hF);
    fetch_chk("oor", 8'h50, 32'h0, 1);
    fetch_chk("oor_mis", 8'h53, 32'h0, 1);
    fetch_chk("far", 8'hFC, 32'h0, 1);

    rd_req = 1; rd_addr = 8'h4C;
    wr_en = 1; wr_addr = 8'h4C; wr_data = 32'h5A5A5A5A; wr_be = 4'hF;
    @(negedge clk);
    rd_req = 0; wr_en = 0;
    check("read_first", a_rd_data, 32'h13131313);
    fetch_chk("after_write", 8'h4C, 32'h5A5A5A5A, 0);

    for (int i = 0; i < 600; i++) begin
      rd_req = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r < 6)      rd_addr = 8'($urandom_range(0, DEPTH - 1) * 4);
      else if (r < 8) rd_addr = 8'($urandom_range(0, 255));
      else            rd_addr = 8'($urandom_range(DEPTH - 1, DEPTH) * 4 + $urandom_range(0, 1) * 2);
      wr_en = ($urandom_range(0, 9) < 3);
      wr_addr = 8'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
      wr_data = $urandom;
      wr_be = 4'($urandom);
      clr_start = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rd_req = 0; wr_en = 0; clr_start = 0;
    repeat (DEPTH + 5) @(negedge clk);

    for (int w = 0; w < DEPTH; w++) wr(8'(w * 4), 32'hDEADBEEF, 4'hF);
    clr_start = 1;
    @(negedge clk);
    clr_start = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_busy", a_clr_busy, 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_clr_done) nd++;
      @(negedge clk);
    end
    check("abort_no_done", nd, 0);
    for (int w = 0; w < DEPTH; w++)
      fetch_chk($sformatf("abort_w%0d", w), 8'(w * 4), (w < 5) ? 32'h0 : 32'hDEADBEEF, 0);

    check("c_valid", c_rd_valid, 0);
    check("c_data", c_rd_data, 0);
    check("c_err", c_rd_err, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised, synchronous-read instruction memory; the next generation of the processor's asynchronous word-addressed instruction store.
- Adds the following:
  - byte-addressed fetch port with a request/valid handshake and configurable read latency;
  - byte-enabled program-load write port, which replaces file reloads between tests;
  - sequential hardware clear engine, so memory can be zeroed between test programs.
- Sits between the fetch stage and the bench/loader.

Parameters:
- DW, 32, data word width in bits; multiple of 8, minimum 8.
- AW, 12, byte-address width.
- DEPTH, 1024, number of words; must be ≤ 2^(AW-OB), where OB = clog2(DW/8).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- CLEAR_ON_RESET, 0, when 1 the clear engine starts automatically on the first cycle after reset deasserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  fetch request.
- rd_addr  in  AW  fetch byte address.
- rd_ready  out  1  fetch request can be accepted this cycle.
- rd_valid  out  1  rd_data/rd_err are valid this cycle.
- rd_data  out  DW  fetched word.
- rd_err  out  1  fetch was misaligned or out of range.
- wr_en  in  1  load-port write strobe.
- wr_addr  in  AW  load byte address; low OB bits ignored.
- wr_data  in  DW  load data.
- wr_be  in  DW/8  byte enables.
- clr_start  in  1  request a full clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset values: rd_valid=0, rd_data=0, rd_err=0, clr_busy=0, clr_done=0, read pipeline flushed, FSM=IDLE.
  - Memory array is not reset.
  - rd_ready=1 out of reset, unless CLEAR_ON_RESET=1 (then 0 once the clear starts).
- Word index = rd_addr[AW-1:OB].
- Fetch handshake:
  - Accept when rd_req && rd_ready.
  - rd_valid asserts exactly RD_LAT cycles after acceptance.
  - Fully pipelined: one accept per cycle, responses in order.
  - rd_valid=0 in any cycle without a corresponding accept.
- Fetch errors:
  - Misaligned (rd_addr[OB-1:0]≠0): rd_err=1, rd_data = word at the index.
  - Out of range (index ≥ DEPTH): rd_err=1, rd_data=0.
  - Both conditions together: rd_err=1, rd_data=0.
- rd_data/rd_err hold their last value when rd_valid=0.
- Load port:
  - Write in the cycle wr_en=1: each byte b where wr_be[b]=1 updates.
  - Writes with index ≥ DEPTH are ignored.
  - Writes are ignored while clr_busy=1.
- Read/write same index, same cycle: read returns the old contents (read-first).
- FSM IDLE:
  - clr_start=1 → CLEAR; counter=0, clr_busy=1, rd_ready=0.
  - CLEAR_ON_RESET=1 forces this transition on the first post-reset cycle.
- FSM CLEAR:
  - Each cycle, write 0 to the word at counter, then counter++.
  - After writing word DEPTH-1 → IDLE; clr_done=1 on the following cycle only, clr_busy=0 in that same cycle.
  - The clear takes exactly DEPTH cycles of clr_busy=1.
- clr_start while clr_busy: ignored; the clear is not restarted.
- clr_start and rd_req in the same cycle from IDLE:
  - The read is accepted, since rd_ready is still 1 that cycle.
  - The clear begins that cycle.
  - Any accepted read may return a partially cleared word.
- Fetches accepted before the clear drain normally; the pipeline is never stalled or flushed except by reset.
- Reset mid-clear: the clear is aborted, clr_busy=0, no clr_done pulse; already-zeroed words stay zero.
- Counter width clog2(DEPTH+1); no wrap.
- DEPTH not a power of two: out-of-range checks apply exactly as stated.

Decomposition:
- Package imem_pkg holds:
  - FSM state enum {ST_IDLE, ST_CLEAR};
  - function clog2;
  - constants RD_LAT_MIN=1, RD_LAT_MAX=2.
- One sub-module, imem_rd_pipe: RD_LAT-deep valid/data/err shift pipeline, parametrised by DW and RD_LAT.
- Array, load port and clear FSM stay in imem_sync.

Test Plan:
- Load+fetch, DW=32, RD_LAT=1:
  - Stimulus: write 0x20080005 at 0x000 with wr_be=4'hF; fetch 0x000.
  - Required: 1 cycle later rd_valid=1, rd_data=0x20080005, rd_err=0.
- Byte enables:
  - Stimulus: write 0xFFFFFFFF at 0x010; then write 0x000000AB with wr_be=4'b0001; fetch 0x010.
  - Required: rd_data=0xFFFFFFAB.
- Back-to-back, RD_LAT=2:
  - Stimulus: fetch 0x000, 0x004, 0x008 on consecutive cycles.
  - Required: rd_valid high for 3 consecutive cycles starting 2 cycles after the first accept; data in order.
- Errors:
  - Fetch 0x002 → rd_err=1, rd_data = word 0.
  - Fetch 0x1000 with AW=13, DEPTH=1024 → rd_err=1, rd_data=0.
- Clear, DEPTH=16:
  - Stimulus: fill all words with 0xDEADBEEF; pulse clr_start.
  - Required: clr_busy high exactly 16 cycles; rd_ready=0 and writes ignored during it; clr_done pulses once; every fetch then returns 0.
- Reset mid-clear, DEPTH=16:
  - Stimulus: after 5 clear cycles, assert reset for 1 cycle.
  - Required: clr_busy=0, no clr_done; words 0–4 read 0, words 5–15 read 0xDEADBEEF.
